// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT/gshare branch predictor with execute-stage redirect resolution
module branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int PRED_MODE   = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [4:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [3:0]       ex_flags,
  input  logic             ex_X,
  input  logic             ex_pred_taken,
  output logic [2:0]       redirect_sel,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] hist;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_cnt;
  logic [1:0]       ex_cnt_next;
  logic             cf, zf, vf, sf;
  logic             actual;
  logic             is_branch;
  logic             mispredict;
  logic             unused_pc;

  assign {cf, zf, vf, sf} = ex_flags;

  // Lookup and update share one hash so training lands where the next fetch looks.
  assign hist   = (PRED_MODE == 2) ? ghr : '0;
  assign if_idx = if_pc[IDX_W+1:2] ^ hist;
  assign ex_idx = ex_pc[IDX_W+1:2] ^ hist;

  assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign pred_taken = (PRED_MODE != 0) && if_valid && bht[if_idx][1];

  always_comb begin
    actual = 1'b0;
    case (ex_funct3)
      3'b000:  actual = zf;
      3'b001:  actual = !zf;
      3'b100:  actual = (sf != vf);
      3'b101:  actual = (sf == vf);
      3'b110:  actual = !cf;
      3'b111:  actual = cf;
      default: actual = 1'b0;
    endcase
  end

  assign is_branch  = ex_valid && (ex_opcode == OP_BRANCH);
  assign mispredict = (ex_pred_taken != actual);

  always_comb begin
    redirect_sel = 3'b000;
    if (ex_valid) begin
      case (ex_opcode)
        OP_BRANCH: if (mispredict) redirect_sel = actual ? 3'b001 : 3'b100;
        OP_JAL:    redirect_sel = 3'b001;
        OP_JALR:   redirect_sel = 3'b010;
        OP_SYSTEM: if (!ex_X) redirect_sel = 3'b011;
        default:   redirect_sel = 3'b000;
      endcase
    end
  end

  assign flush = (redirect_sel != 3'b000);

  assign ex_cnt = bht[ex_idx];

  always_comb begin
    ex_cnt_next = ex_cnt;
    if (actual && ex_cnt != 2'b11)
      ex_cnt_next = ex_cnt + 2'b01;
    else if (!actual && ex_cnt != 2'b00)
      ex_cnt_next = ex_cnt - 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      ghr <= '0;
    end else if (is_branch && PRED_MODE != 0) begin
      bht[ex_idx] <= ex_cnt_next;
      if (PRED_MODE == 2) ghr <= {ghr[IDX_W-2:0], actual};
    end
  end

  // Statistics run in every mode, including static not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (is_branch) begin
      branch_count <= branch_count + 1'b1;
      if (mispredict) mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule
